// File: rtl/division_if.sv
// Handshake and data bundle between the control FSM (master) and the
// multicycle divider (slave).
//  master: drives workDiv, lhs, rhs; observes results and status
//  slave : consumes start/operands; drives lo, hi, endDiv, divZero, busy,
//          DivCounter
interface division_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
);
  logic             workDiv;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             endDiv;
  logic             divZero;
  logic             busy;
  logic [CNT_W-1:0] DivCounter;

  modport master (
    output workDiv, lhs, rhs,
    input  lo, hi, endDiv, divZero, busy, DivCounter
  );

  modport slave (
    input  workDiv, lhs, rhs,
    output lo, hi, endDiv, divZero, busy, DivCounter
  );
endinterface

// File: rtl/division.sv
// Multicycle signed divider (MIPS div), restoring shift-subtract, one
// quotient bit per clock. Quotient goes to lo, remainder to hi.
//  Clk   : clock, rising edge
//  reset : asynchronous, active-low reset
//  bus   : division_if.slave (workDiv/lhs/rhs in; lo/hi/endDiv/divZero/
//          busy/DivCounter out, all registered)
module division #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      Clk,
  input  logic      reset,
  division_if.slave bus
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;    // dividend magnitude, shifted out MSB first
  logic [EXT_W-1:0] r_dsr;    // divisor magnitude; 33 bits so |0x80000000| fits
  logic [WIDTH-1:0] r_rem;    // partial remainder, always < divisor
  logic [WIDTH-1:0] r_quo;    // quotient magnitude
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_end;
  logic             r_dz;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic [EXT_W-1:0] w_rem_sh;
  logic             w_ge;
  logic             w_rhs_zero;
  logic [WIDTH-1:0] w_lhs_mag;
  logic [EXT_W-1:0] w_rhs_mag;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  // One restoring step: bring in next dividend bit, trial-compare.
  assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= r_dsr);

  // Operand magnitudes; divisor negated in 33 bits to cover 0x80000000.
  assign w_rhs_zero = (bus.rhs == '0);
  assign w_lhs_mag  = bus.lhs[WIDTH-1] ? (~bus.lhs + WIDTH'(1)) : bus.lhs;
  assign w_rhs_mag  = bus.rhs[WIDTH-1] ? (~{1'b1, bus.rhs} + EXT_W'(1))
                                       : {1'b0, bus.rhs};

  // Sign restore: quotient truncates toward zero, remainder follows dividend.
  assign w_lo_fix   = r_qneg ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_hi_fix   = r_rneg ? (~r_rem + WIDTH'(1)) : r_rem;

  // Control FSM and datapath registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_end   <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.workDiv) begin
            r_dvd  <= w_lhs_mag;
            r_dsr  <= w_rhs_mag;
            r_rem  <= '0;
            r_quo  <= '0;
            r_qneg <= bus.lhs[WIDTH-1] ^ bus.rhs[WIDTH-1];
            r_rneg <= bus.lhs[WIDTH-1];
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_dz   <= w_rhs_zero;
            r_state <= w_rhs_zero ? S_DONE : S_RUN;
          end
        end

        S_RUN: begin
          r_rem <= w_ge ? WIDTH'(w_rem_sh - r_dsr) : WIDTH'(w_rem_sh);
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          r_lo    <= w_lo_fix;
          r_hi    <= w_hi_fix;
          r_end   <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          // Entered from FIX with endDiv already raised; the divide-by-zero
          // path arrives with it low and spends one extra cycle raising it.
          if (r_end) begin
            r_end   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_end <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.lo         = r_lo;
  assign bus.hi         = r_hi;
  assign bus.endDiv     = r_end;
  assign bus.divZero    = r_dz;
  assign bus.busy       = r_busy;
  assign bus.DivCounter = r_cnt;

endmodule

// File: tb/tb_division.sv
// Directed testbench for the multicycle signed divider.
module tb_division;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side model of the result registers (hold across runs).
  logic [31:0] m_lo = '0;
  logic [31:0] m_hi = '0;

  division_if #(.WIDTH(32), .CNT_W(6)) u_if ();

  division #(.WIDTH(32), .CNT_W(6)) u_dut (
    .Clk   (clk),
    .reset (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start a division, wait for endDiv, check latency/results/pulse width.
  // pulse_at > 0 injects a workDiv pulse with new operands mid-run.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edz, input int pulse_at);
    int  n;
    bit  seen;
    @(negedge clk);
    u_if.workDiv = 1'b1;
    u_if.lhs     = a;
    u_if.rhs     = b;
    @(posedge clk);
    #1;
    u_if.workDiv = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (n == pulse_at) begin
        u_if.workDiv = 1'b1;
        u_if.lhs     = 32'd50;
        u_if.rhs     = 32'd3;
        check({tag, "_busy_mid"}, 32'(u_if.busy), 32'd1);
      end else begin
        u_if.workDiv = 1'b0;
      end
      if (n == 3) begin
        check({tag, "_lo_hold"}, u_if.lo, m_lo);
        check({tag, "_hi_hold"}, u_if.hi, m_hi);
      end
      if (u_if.endDiv) seen = 1'b1;
    end
    u_if.workDiv = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_lo"}, u_if.lo, elo);
    check({tag, "_hi"}, u_if.hi, ehi);
    check({tag, "_divzero"}, 32'(u_if.divZero), 32'(edz));
    @(negedge clk);
    check({tag, "_end_pulse"}, 32'(u_if.endDiv), 32'd0);
    check({tag, "_busy_off"}, 32'(u_if.busy), 32'd0);
    m_lo = elo;
    m_hi = ehi;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lo"}, u_if.lo, 32'd0);
    check({tag, "_hi"}, u_if.hi, 32'd0);
    check({tag, "_end"}, 32'(u_if.endDiv), 32'd0);
    check({tag, "_dz"}, 32'(u_if.divZero), 32'd0);
    check({tag, "_busy"}, 32'(u_if.busy), 32'd0);
    check({tag, "_cnt"}, 32'(u_if.DivCounter), 32'd0);
  endtask

  // Reset in the middle of a run once DivCounter reaches 10.
  task automatic reset_mid_run();
    int n;
    @(negedge clk);
    u_if.workDiv = 1'b1;
    u_if.lhs     = 32'd100;
    u_if.rhs     = 32'd7;
    @(posedge clk);
    #1;
    u_if.workDiv = 1'b0;
    n = 0;
    while (32'(u_if.DivCounter) != 32'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_cnt_reached", 32'(u_if.DivCounter), 32'd10);
    check("rst_mid_busy", 32'(u_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_end", 32'(u_if.endDiv), 32'd0);
    end
    rst_n = 1'b1;
    m_lo = '0;
    m_hi = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.endDiv) check("rst_mid_spurious_end", 32'(u_if.endDiv), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    u_if.workDiv = 1'b0;
    u_if.lhs     = '0;
    u_if.rhs     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    run_div("d100_7",  32'd100,        32'd7,          34, 32'd14,         32'd2,          1'b0, 0);
    run_div("dm7_2",   32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
    run_div("d7_m2",   32'd7,          32'hFFFF_FFFE,  34, 32'hFFFF_FFFD,  32'd1,          1'b0, 0);

    reset_mid_run();
    run_div("d100_7b", 32'd100,        32'd7,          34, 32'd14,         32'd2,          1'b0, 0);

    run_div("d59_10",  32'd59,         32'd10,         34, 32'd5,          32'd9,          1'b0, 0);
    run_div("d7_0",    32'd7,          32'd0,           2, 32'd5,          32'd9,          1'b1, 0);
    check("dz_sticky", 32'(u_if.divZero), 32'd1);
    run_div("dmin_m1", 32'h8000_0000,  32'hFFFF_FFFF,  34, 32'h8000_0000,  32'd0,          1'b0, 0);
    run_div("d0_5",    32'd0,          32'd5,          34, 32'd0,          32'd0,          1'b0, 0);
    run_div("dmin_2",  32'h8000_0000,  32'd2,          34, 32'hC000_0000,  32'd0,          1'b0, 0);
    run_div("d1000_7", 32'd1000,       32'd7,          34, 32'd142,        32'd6,          1'b0, 5);
    check("post_pulse_idle", 32'(u_if.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
